// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - control, instruction memory and IR signals of the fetch unit
// master: fetch unit side; slave: control/memory/IR side. StallCount exists only with IFETCH_STALL_CNT_EN.
interface instruction_fetch_unit_if;
  logic        FetchReq;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        MemRead;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic [31:0] MemData;
  logic [31:0] Instruction;
  logic        IRWrite;
  logic [31:0] PC;
  logic        FetchBusy;
  logic        FetchErr;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  modport master (
    input  FetchReq, Redirect, RedirectPC, MemReady, MemData,
    output MemRead, MemAddr, Instruction, IRWrite, PC, FetchBusy, FetchErr
`ifdef IFETCH_STALL_CNT_EN
    , output StallCount
`endif
  );

  modport slave (
    output FetchReq, Redirect, RedirectPC, MemReady, MemData,
    input  MemRead, MemAddr, Instruction, IRWrite, PC, FetchBusy, FetchErr
`ifdef IFETCH_STALL_CNT_EN
    , input StallCount
`endif
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - multicycle fetch sequencer feeding the instruction register
// Optional stall counter output enabled by IFETCH_STALL_CNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned PC_STEP        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                      Clk,
  input  logic                      Reset,
  instruction_fetch_unit_if.master  bus
);

  localparam logic [31:0] STEP     = 32'(PC_STEP);
  localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DELIVER, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_read_q, mem_read_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic        irwrite_q, irwrite_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [31:0] redir_pc;

  assign redir_pc = bus.RedirectPC & 32'hFFFF_FFFC;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_read_d = mem_read_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;
    irwrite_d  = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    tcnt_d     = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.Redirect) begin
          pc_d = redir_pc;
        end else if (bus.FetchReq) begin
          state_d    = S_REQ;
          mem_read_d = 1'b1;
          mem_addr_d = pc_q;
          tcnt_d     = 8'd0;
          busy_d     = 1'b1;
        end
      end
      S_REQ: begin
        // Redirect wins over a same-cycle MemReady: the fetched word is stale
        if (bus.Redirect) begin
          state_d    = S_IDLE;
          mem_read_d = 1'b0;
          pc_d       = redir_pc;
          busy_d     = 1'b0;
        end else if (bus.MemReady) begin
          state_d    = S_DELIVER;
          instr_d    = bus.MemData;
          mem_read_d = 1'b0;
          irwrite_d  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
          if (tcnt_d == TO_LIMIT) begin
            state_d    = S_ERR;
            mem_read_d = 1'b0;
            err_d      = 1'b1;
            busy_d     = 1'b0;
          end
        end
      end
      S_DELIVER: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        pc_d    = bus.Redirect ? redir_pc : pc_q + STEP;
      end
      S_ERR: begin
        if (bus.Redirect) begin
          state_d = S_IDLE;
          pc_d    = redir_pc;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      mem_read_q <= 1'b0;
      mem_addr_q <= RESET_PC;
      instr_q    <= 32'h0;
      irwrite_q  <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tcnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_read_q <= mem_read_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
      irwrite_q  <= irwrite_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tcnt_q     <= tcnt_d;
    end
  end

  assign bus.MemRead     = mem_read_q;
  assign bus.MemAddr     = mem_addr_q;
  assign bus.Instruction = instr_q;
  assign bus.IRWrite     = irwrite_q;
  assign bus.PC          = pc_q;
  assign bus.FetchBusy   = busy_q;
  assign bus.FetchErr    = err_q;

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_REQ && !bus.MemReady && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.StallCount = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  logic [31:0] d;
  int rd;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_before;
`endif

  instruction_fetch_unit_if bus();

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP(4),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Every IR write must match the oldest word the memory model handed out
  always @(negedge Clk) begin
    if (Reset && bus.IRWrite === 1'b1) begin
      if (sb.size() == 0) chk1("spurious_irwrite", bus.IRWrite, 1'b0);
      else chk("instruction", bus.Instruction, sb.pop_front());
    end
  end

  task automatic do_fetch(input string tag, input int stalls, input logic [31:0] data,
                          input logic [31:0] addr);
    int reads = 0;
    int writes = 0;
    int first_wr = -1;
    bit pushed = 0;
    logic [31:0] seen_addr = addr;
    bus.FetchReq = 1'b1;
    bus.MemReady = 1'b0;
    @(negedge Clk);
    bus.FetchReq = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.MemRead) begin
        reads++;
        if (bus.MemAddr !== addr) seen_addr = bus.MemAddr;
      end
      if (bus.IRWrite) begin
        if (writes == 0) first_wr = i;
        writes++;
      end else if (writes > 0) begin
        break;
      end
      bus.MemReady = bus.MemRead && (reads > stalls);
      bus.MemData  = data;
      if (bus.MemReady && !pushed) begin
        sb.push_back(data);
        pushed = 1;
      end
      @(negedge Clk);
    end
    bus.MemReady = 1'b0;
    chk({tag, "_memread_cycles"}, 32'(reads), 32'(stalls + 1));
    chk({tag, "_memaddr"}, seen_addr, addr);
    chk({tag, "_irwrite_cycles"}, 32'(writes), 32'd1);
    chk({tag, "_irwrite_latency"}, 32'(first_wr), 32'(stalls + 1));
  endtask

  initial begin
    bus.FetchReq   = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.MemReady   = 1'b0;
    bus.MemData    = 32'h0;
    #1 Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk1("rst_memread", bus.MemRead, 1'b0);
    chk("rst_memaddr", bus.MemAddr, 32'h0);
    chk("rst_instruction", bus.Instruction, 32'h0);
    chk1("rst_irwrite", bus.IRWrite, 1'b0);
    chk("rst_pc", bus.PC, 32'h0);
    chk1("rst_busy", bus.FetchBusy, 1'b0);
    chk1("rst_fetcherr", bus.FetchErr, 1'b0);
`ifdef IFETCH_STALL_CNT_EN
    chk("rst_stallcount", 32'(bus.StallCount), 32'h0);
`endif
    Reset = 1'b1;
    @(negedge Clk);

    do_fetch("t2", 0, 32'h8C22_0004, 32'h0);
    chk("t2_pc", bus.PC, 32'h4);

`ifdef IFETCH_STALL_CNT_EN
    stall_before = bus.StallCount;
`endif
    do_fetch("t3", 3, 32'h0123_4567, 32'h4);
    chk("t3_pc", bus.PC, 32'h8);
`ifdef IFETCH_STALL_CNT_EN
    chk("t3_stallcount", 32'(bus.StallCount - stall_before), 32'd3);
`endif

    // Reset while a request is outstanding
    bus.FetchReq = 1'b1;
    @(negedge Clk);
    bus.FetchReq = 1'b0;
    chk1("t1_memread_pre", bus.MemRead, 1'b1);
    #2 Reset = 1'b0;
    #1;
    chk1("t1_memread", bus.MemRead, 1'b0);
    chk("t1_pc", bus.PC, 32'h0);
    chk1("t1_irwrite", bus.IRWrite, 1'b0);
    chk1("t1_fetcherr", bus.FetchErr, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk1("t1_idle_busy", bus.FetchBusy, 1'b0);
    chk1("t1_idle_memread", bus.MemRead, 1'b0);

    exp_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      do_fetch("rnd", int'($urandom_range(0, 2)), d, exp_pc);
      exp_pc = exp_pc + 32'd4;
      chk("rnd_pc", bus.PC, exp_pc);
    end

    // Memory never answers
`ifdef IFETCH_STALL_CNT_EN
    stall_before = bus.StallCount;
`endif
    rd = 0;
    bus.FetchReq = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      bus.FetchReq = 1'b0;
      if (bus.FetchErr) break;
      if (bus.MemRead) rd++;
    end
    chk("t4_stall_cycles", 32'(rd), 32'd15);
    chk1("t4_fetcherr", bus.FetchErr, 1'b1);
    chk1("t4_memread", bus.MemRead, 1'b0);
`ifdef IFETCH_STALL_CNT_EN
    chk("t4_stallcount", 32'(bus.StallCount - stall_before), 32'd15);
`endif
    bus.FetchReq = 1'b1;
    @(negedge Clk);
    bus.FetchReq = 1'b0;
    @(negedge Clk);
    chk1("t4_err_hold", bus.FetchErr, 1'b1);
    chk1("t4_err_no_read", bus.MemRead, 1'b0);
    chk("t4_err_pc", bus.PC, exp_pc);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h100;
    @(negedge Clk);
    bus.Redirect = 1'b0;
    chk1("t4_err_cleared", bus.FetchErr, 1'b0);
    chk("t4_redirect_pc", bus.PC, 32'h100);
    do_fetch("t4_after", 0, 32'hCAFE_F00D, 32'h100);
    chk("t4_after_pc", bus.PC, 32'h104);

    // Redirect on the second REQ cycle, same cycle as MemReady
    bus.FetchReq = 1'b1;
    @(negedge Clk);
    bus.FetchReq = 1'b0;
    @(negedge Clk);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h203;
    bus.MemReady   = 1'b1;
    bus.MemData    = 32'hDEAD_BEEF;
    @(negedge Clk);
    bus.Redirect = 1'b0;
    bus.MemReady = 1'b0;
    chk1("t5_memread", bus.MemRead, 1'b0);
    chk("t5_pc", bus.PC, 32'h200);
    chk1("t5_irwrite", bus.IRWrite, 1'b0);
    chk1("t5_busy", bus.FetchBusy, 1'b0);
    @(negedge Clk);
    chk1("t5_irwrite_late", bus.IRWrite, 1'b0);

    // Redirect beats FetchReq in IDLE, then fetch at the top of the address space
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFFC;
    bus.FetchReq   = 1'b1;
    @(negedge Clk);
    bus.Redirect = 1'b0;
    bus.FetchReq = 1'b0;
    chk("t6_redirect_pc", bus.PC, 32'hFFFF_FFFC);
    chk1("t6_fetchreq_dropped", bus.MemRead, 1'b0);
    do_fetch("t6_wrap", 1, 32'h2108_0001, 32'hFFFF_FFFC);
    chk("t6_wrap_pc", bus.PC, 32'h0);

    // Redirect during DELIVER: word still delivered, PC takes the redirect
    d = 32'h1234_5678;
    bus.FetchReq = 1'b1;
    bus.MemReady = 1'b1;
    bus.MemData  = d;
    sb.push_back(d);
    @(negedge Clk);
    bus.FetchReq = 1'b0;
    @(negedge Clk);
    chk1("t6_deliver_irwrite", bus.IRWrite, 1'b1);
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h40;
    bus.MemReady   = 1'b0;
    @(negedge Clk);
    bus.Redirect = 1'b0;
    chk("t6_deliver_pc", bus.PC, 32'h40);
    chk1("t6_deliver_irwrite_off", bus.IRWrite, 1'b0);

    @(negedge Clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
